// File: rtl/pattern_tx_pkg.sv
// Shared types and helpers for the serial test-pattern transmitter.
package pattern_tx_pkg;

    // Default maximum pattern length in bits.
    localparam int W_DEFAULT = 16;

    // Transmitter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Requested lengths beyond the pattern register width send the whole register.
    function automatic int unsigned clamp_len(input int unsigned len_req,
                                              input int unsigned max_len);
        return (len_req > max_len) ? max_len : len_req;
    endfunction

endpackage

// File: rtl/pattern_tx_run_tracker.sv
// Tracks the current and longest runs of consecutive 1s seen on the serial line.
module run_tracker
    import pattern_tx_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          bit_in,
    output logic [CW-1:0] max_run
);

    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] LIMIT = CW'(W);

    logic [CW-1:0] cur_run;
    logic [CW-1:0] cur_next;

    // Run lengths stop counting at W so they never wrap in the CW-bit field.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= LIMIT) ? v : v + ONE;
    endfunction

    // Next run length: extend on a 1, restart on a 0.
    always_comb begin
        cur_next = '0;
        if (bit_in) begin
            cur_next = sat_inc(cur_run);
        end
    end

    // Run registers; max_run lags the counted bit by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_run <= '0;
            max_run <= '0;
        end else if (clear) begin
            cur_run <= '0;
            max_run <= '0;
        end else begin
            cur_run <= cur_next;
            if (cur_next > max_run) begin
                max_run <= cur_next;
            end
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// Serial test-pattern transmitter: sends a captured pattern LSB first,
// repeated with a one-cycle 0 gap between repetitions, and reports the
// longest run of 1s it drove.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [CW-1:0] len,
    input  logic [3:0]    reps,
    output logic          ready,
    output logic          d,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] max_run
);

    localparam int            IW  = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state;
    state_t        state_next;

    logic [W-1:0]  pat_r;
    logic [CW-1:0] len_r;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_next;
    logic [3:0]    rep_cnt;
    logic [3:0]    rep_cnt_next;
    logic          d_next;
    logic          load;

    logic [CW-1:0] len_eff;
    logic [3:0]    reps_eff;
    logic [CW-1:0] nxt_idx;
    logic [IW-1:0] nxt_bit;

    // Accept-time normalisation of the request fields.
    assign len_eff  = CW'(clamp_len(32'(len), W));
    assign reps_eff = (reps == 4'd0) ? 4'd1 : reps;

    // bit_cnt is the index of the bit currently on d; nxt_idx is the one to load next.
    assign nxt_idx = bit_cnt + ONE;
    assign nxt_bit = nxt_idx[IW-1:0];

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT) || (state == GAP);
    assign done  = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter and next-bit logic.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        rep_cnt_next = rep_cnt;
        d_next       = 1'b0;
        load         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load         = 1'b1;
                    bit_cnt_next = '0;
                    rep_cnt_next = reps_eff;
                    if (len_eff == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                        d_next     = pattern[0];
                    end
                end
            end
            SHIFT: begin
                if (nxt_idx == len_r) begin
                    bit_cnt_next = '0;
                    if (rep_cnt > 4'd1) begin
                        rep_cnt_next = rep_cnt - 4'd1;
                        state_next   = GAP;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    bit_cnt_next = nxt_idx;
                    d_next       = pat_r[nxt_bit];
                end
            end
            GAP: begin
                state_next   = SHIFT;
                bit_cnt_next = '0;
                d_next       = pat_r[0];
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture registers, counters and the registered serial output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r   <= '0;
            len_r   <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            d       <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt_next;
            rep_cnt <= rep_cnt_next;
            d       <= d_next;
            if (load) begin
                pat_r <= pattern;
                len_r <= len_eff;
            end
        end
    end

    run_tracker #(
        .W  (W),
        .CW (CW)
    ) u_run_tracker (
        .clk     (clk),
        .reset   (reset),
        .clear   (load),
        .bit_in  (d),
        .max_run (max_run)
    );

endmodule
